// File: rtl/roi_pkg.sv
// roi_pkg: shared definitions for the ROI scheduler.
// Holds the FSM state type, the bit positions of the packed coordinate
// word (x in [26:16], y in [9:0]) and helpers to pack/unpack that word.
package roi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } roi_sched_state_t;

  localparam int X_MSB = 26;
  localparam int X_LSB = 16;
  localparam int Y_MSB = 9;
  localparam int Y_LSB = 0;

  localparam int XW     = X_MSB - X_LSB + 1;
  localparam int YW     = Y_MSB - Y_LSB + 1;
  localparam int WORD_W = 32;

  function automatic logic [XW-1:0] unpack_x(input logic [WORD_W-1:0] w);
    return w[X_MSB:X_LSB];
  endfunction

  function automatic logic [YW-1:0] unpack_y(input logic [WORD_W-1:0] w);
    return w[Y_MSB:Y_LSB];
  endfunction

  function automatic logic [WORD_W-1:0] pack_xy(input logic [XW-1:0] x,
                                                input logic [YW-1:0] y);
    logic [WORD_W-1:0] w;
    w              = '0;
    w[X_MSB:X_LSB] = x;
    w[Y_MSB:Y_LSB] = y;
    return w;
  endfunction

endpackage

// File: rtl/roi_sched_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a one-hot grant.
// The requester at or after the pointer wins; the pointer moves just past
// the winner whenever a grant is issued (a grant is an accept here).
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] win;
  logic          found;

  // Search from the pointer to the top, then wrap to the bottom.
  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (en && !found && req[i] && (PW'(i) >= ptr_q)) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        win    = PW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (en && !found && req[i]) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        win    = PW'(i);
      end
    end
    ptr_d = (win == PW'(N - 1)) ? '0 : win + PW'(1);
  end

  // Advance the pointer past the winner on every accept.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ptr_q <= '0;
    end else if (|gnt) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/roi_sched.sv
// roi_sched: frame-synchronous ROI scheduler.
// Accepts ROI requests round-robin, validates and normalises them into a
// one-deep shadow slot, and commits the slot only at pixel-stream frame
// boundaries so coordinates never change mid-frame.
// Build option ROI_SCHED_REPEAT_EN: the active ROI persists across frames
// until replaced; without it each accepted ROI covers exactly one frame.
module roi_sched
  import roi_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int WIDTH     = 800,
  parameter int HEIGHT    = 600,
  parameter int BIT_COORD = 32,
  parameter int IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk_i,
  input  logic                       arst_ni,
  input  logic [N_REQ-1:0]           req_valid_i,
  output logic [N_REQ-1:0]           req_ready_o,
  input  logic [N_REQ*BIT_COORD-1:0] req_xy0_i,
  input  logic [N_REQ*BIT_COORD-1:0] req_xy1_i,
  input  logic                       tvalid_i,
  input  logic                       tlast_i,
  output logic [BIT_COORD-1:0]       xy_0_o,
  output logic [BIT_COORD-1:0]       xy_1_o,
  output logic                       roi_en_o,
  output logic [IDW-1:0]             act_id_o,
  output logic                       done_o,
  output logic [IDW-1:0]             done_id_o,
  output logic                       err_o,
  output logic [IDW-1:0]             err_id_o
);

  localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

  roi_sched_state_t  state_q, state_d;
  logic              sof_q;
  logic              bnd;
  logic              slot_full_q;
  logic [WORD_W-1:0] slot_xy0_q, slot_xy1_q;
  logic [IDW-1:0]    slot_id_q;
  logic [N_REQ-1:0]  gnt;
  logic              accept, req_ok, commit, frame_end;
  logic [IDW-1:0]    sel_id;
  logic [XW-1:0]     sel_x0, sel_x1;
  logic [YW-1:0]     sel_y0, sel_y1;
  logic [WORD_W-1:0] norm_xy0, norm_xy1;
  logic              unused_field_bits;

  // Bits outside the x/y fields carry no meaning; folding them here marks them as intentionally ignored.
  assign unused_field_bits = ^{req_xy0_i, req_xy1_i};

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk    (clk_i),
    .arst_n (arst_ni),
    .req    (req_valid_i),
    .en     (!slot_full_q),
    .gnt    (gnt)
  );

  assign req_ready_o = gnt;
  assign accept      = |gnt;
  assign bnd         = (tvalid_i && tlast_i) || (sof_q && !tvalid_i);
  assign roi_en_o    = (state_q == RUN);

  // Route the granted requester's corners and id to the validation logic.
  always_comb begin
    sel_id = '0;
    sel_x0 = '0;
    sel_y0 = '0;
    sel_x1 = '0;
    sel_y1 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_id = IDW'(i);
        sel_x0 = unpack_x(WORD_W'(req_xy0_i[i*BIT_COORD +: BIT_COORD]));
        sel_y0 = unpack_y(WORD_W'(req_xy0_i[i*BIT_COORD +: BIT_COORD]));
        sel_x1 = unpack_x(WORD_W'(req_xy1_i[i*BIT_COORD +: BIT_COORD]));
        sel_y1 = unpack_y(WORD_W'(req_xy1_i[i*BIT_COORD +: BIT_COORD]));
      end
    end
  end

  assign req_ok   = (sel_x0 <= X_MAX) && (sel_x1 <= X_MAX) &&
                    (sel_y0 <= Y_MAX) && (sel_y1 <= Y_MAX);
  assign norm_xy0 = pack_xy((sel_x0 < sel_x1) ? sel_x0 : sel_x1,
                            (sel_y0 < sel_y1) ? sel_y0 : sel_y1);
  assign norm_xy1 = pack_xy((sel_x0 < sel_x1) ? sel_x1 : sel_x0,
                            (sel_y0 < sel_y1) ? sel_y1 : sel_y0);

  // FSM state register.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Decide when to commit the slot and when a frame under the active ROI ends.
  always_comb begin
    state_d   = state_q;
    commit    = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (slot_full_q && bnd) begin
          commit  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (tvalid_i && tlast_i) begin
          frame_end = 1'b1;
          if (slot_full_q) begin
            commit = 1'b1;
          end else begin
`ifdef ROI_SCHED_REPEAT_EN
            state_d = RUN;
`else
            state_d = IDLE;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame tracking, shadow slot, committed corners and the done/err pulses.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      sof_q       <= 1'b1;
      slot_full_q <= 1'b0;
      slot_xy0_q  <= '0;
      slot_xy1_q  <= '0;
      slot_id_q   <= '0;
      xy_0_o      <= '0;
      xy_1_o      <= '0;
      act_id_o    <= '0;
      done_o      <= 1'b0;
      done_id_o   <= '0;
      err_o       <= 1'b0;
      err_id_o    <= '0;
    end else begin
      if (tvalid_i) begin
        sof_q <= tlast_i;
      end
      done_o <= frame_end;
      if (frame_end) begin
        done_id_o <= act_id_o;
      end
      err_o <= accept && !req_ok;
      if (accept && !req_ok) begin
        err_id_o <= sel_id;
      end
      if (commit) begin
        xy_0_o      <= BIT_COORD'(slot_xy0_q);
        xy_1_o      <= BIT_COORD'(slot_xy1_q);
        act_id_o    <= slot_id_q;
        slot_full_q <= 1'b0;
      end else if (accept && req_ok) begin
        slot_full_q <= 1'b1;
        slot_xy0_q  <= norm_xy0;
        slot_xy1_q  <= norm_xy1;
        slot_id_q   <= sel_id;
      end
    end
  end

endmodule

// File: tb/tb_roi_sched.sv
// tb_roi_sched: self-checking bench for roi_sched (N_REQ=2, 800x600 limits).
// Accepted requests are pushed to a scoreboard by an accept monitor; a
// frame-level model moves them to the active ROI at frame boundaries and
// predicts done/err pulses, which are popped when the DUT emits them.
module tb_roi_sched;

  typedef struct packed {
    logic [31:0] xy0;
    logic [31:0] xy1;
    int          id;
  } roi_t;

  logic        clk_i;
  logic        arst_ni;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [63:0] req_xy0_i;
  logic [63:0] req_xy1_i;
  logic        tvalid_i;
  logic        tlast_i;
  logic [31:0] xy_0_o;
  logic [31:0] xy_1_o;
  logic        roi_en_o;
  logic [0:0]  act_id_o;
  logic        done_o;
  logic [0:0]  done_id_o;
  logic        err_o;
  logic [0:0]  err_id_o;

  int   n_total = 0;
  int   n_bad   = 0;
  int   done_seen = 0;
  roi_t pend_q[$];
  int   done_q[$];
  int   err_q[$];
  roi_t act;
  bit   run;
  int   rr_ptr;

  int          m_exp_w, m_j, m_x0, m_y0, m_x1, m_y1, m_e;
  logic [31:0] m_w0, m_w1;
  roi_t        m_r;

  roi_sched #(
    .N_REQ(2), .WIDTH(800), .HEIGHT(600), .BIT_COORD(32)
  ) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_xy0_i   (req_xy0_i),
    .req_xy1_i   (req_xy1_i),
    .tvalid_i    (tvalid_i),
    .tlast_i     (tlast_i),
    .xy_0_o      (xy_0_o),
    .xy_1_o      (xy_1_o),
    .roi_en_o    (roi_en_o),
    .act_id_o    (act_id_o),
    .done_o      (done_o),
    .done_id_o   (done_id_o),
    .err_o       (err_o),
    .err_id_o    (err_id_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int x, input int y);
    logic [31:0] w;
    w        = '0;
    w[26:16] = x[10:0];
    w[9:0]   = y[9:0];
    return w;
  endfunction

  task automatic checkActive(input string tag);
    checkOutput({tag, "_en"}, roi_en_o, run);
    checkOutput({tag, "_xy0"}, xy_0_o, act.xy0);
    checkOutput({tag, "_xy1"}, xy_1_o, act.xy1);
    checkOutput({tag, "_id"}, act_id_o, act.id);
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_en"}, roi_en_o, 0);
    checkOutput({tag, "_xy0"}, xy_0_o, 0);
    checkOutput({tag, "_xy1"}, xy_1_o, 0);
    checkOutput({tag, "_id"}, act_id_o, 0);
    checkOutput({tag, "_done"}, done_o, 0);
    checkOutput({tag, "_err"}, err_o, 0);
    checkOutput({tag, "_doneid"}, done_id_o, 0);
    checkOutput({tag, "_errid"}, err_id_o, 0);
  endtask

  task automatic modelStart();
    if (!run && pend_q.size() > 0) begin
      act = pend_q.pop_front();
      run = 1'b1;
    end
  endtask

  task automatic modelEnd();
    if (pend_q.size() > 0) begin
      act = pend_q.pop_front();
      run = 1'b1;
    end else begin
`ifndef ROI_SCHED_REPEAT_EN
      run = 1'b0;
`endif
    end
  endtask

  task automatic modelReset();
    run = 1'b0;
    act = '0;
    pend_q.delete();
    rr_ptr = 0;
  endtask

  // Drive one request and wait (bounded) for its accept.
  task automatic applyStimulus(input int id, input int x0, input int y0, input int x1, input int y1);
    bit ok;
    int cyc;
    ok = (x0 < 800) && (x1 < 800) && (y0 < 600) && (y1 < 600);
    @(posedge clk_i); #1;
    req_xy0_i[id*32 +: 32] = mk(x0, y0);
    req_xy1_i[id*32 +: 32] = mk(x1, y1);
    req_valid_i[id] = 1'b1;
    cyc = 0;
    @(negedge clk_i);
    while (!req_ready_o[id] && cyc < 300) begin
      @(negedge clk_i);
      cyc++;
    end
    if (!req_ready_o[id]) begin
      checkOutput("req_timeout", req_ready_o[id], 1);
      req_valid_i[id] = 1'b0;
    end else begin
      @(posedge clk_i); #1;
      req_valid_i[id] = 1'b0;
      @(negedge clk_i);
      checkOutput("err_pulse", err_o, !ok);
    end
  endtask

  // Gap cycles followed by one frame of beats ending in tlast.
  task automatic runFrame(input int beats);
    bit was_run;
    repeat (4) begin
      @(posedge clk_i); #1;
    end
    modelStart();
    for (int b = 0; b < beats; b++) begin
      @(posedge clk_i); #1;
      tvalid_i = 1'b1;
      tlast_i  = (b == beats - 1);
      if (b == beats - 1 && run) done_q.push_back(act.id);
      @(negedge clk_i);
      if (b == 0) checkActive("beat_first");
      if (b == beats - 1) checkActive("beat_last");
    end
    was_run = run;
    @(posedge clk_i); #1;
    tvalid_i = 1'b0;
    tlast_i  = 1'b0;
    modelEnd();
    @(negedge clk_i);
    checkOutput("done_pulse", done_o, was_run);
    checkActive("after_last");
  endtask

  // Accept monitor (pushes scoreboard entries) and done/err consumer.
  always @(negedge clk_i) begin
    if (arst_ni) begin
      if (req_ready_o != 2'b00) checkOutput("one_ready", $countones(req_ready_o), 1);
      for (int i = 0; i < 2; i++) begin
        if (req_valid_i[i] && req_ready_o[i]) begin
          m_exp_w = -1;
          for (int k = 0; k < 2; k++) begin
            m_j = (rr_ptr + k) % 2;
            if (m_exp_w < 0 && req_valid_i[m_j]) m_exp_w = m_j;
          end
          checkOutput("rr_order", i, m_exp_w);
          rr_ptr = (i + 1) % 2;
          m_w0 = req_xy0_i[i*32 +: 32];
          m_w1 = req_xy1_i[i*32 +: 32];
          m_x0 = int'(m_w0[26:16]);
          m_y0 = int'(m_w0[9:0]);
          m_x1 = int'(m_w1[26:16]);
          m_y1 = int'(m_w1[9:0]);
          if (m_x0 < 800 && m_x1 < 800 && m_y0 < 600 && m_y1 < 600) begin
            m_r.xy0 = mk((m_x0 < m_x1) ? m_x0 : m_x1, (m_y0 < m_y1) ? m_y0 : m_y1);
            m_r.xy1 = mk((m_x0 < m_x1) ? m_x1 : m_x0, (m_y0 < m_y1) ? m_y1 : m_y0);
            m_r.id  = i;
            pend_q.push_back(m_r);
          end else begin
            err_q.push_back(i);
          end
        end
      end
      if (done_o) begin
        done_seen++;
        if (done_q.size() == 0) checkOutput("done_unexp", done_o, 0);
        else begin
          m_e = done_q.pop_front();
          checkOutput("done_id", done_id_o, m_e);
        end
      end
      if (err_o) begin
        if (err_q.size() == 0) checkOutput("err_unexp", err_o, 0);
        else begin
          m_e = err_q.pop_front();
          checkOutput("err_id", err_id_o, m_e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int exp_d;
    arst_ni     = 1'b0;
    req_valid_i = '0;
    req_xy0_i   = '0;
    req_xy1_i   = '0;
    tvalid_i    = 1'b0;
    tlast_i     = 1'b0;
    modelReset();
    #12;
    checkCleared("rst");
    checkOutput("rst_ready", req_ready_o, 0);
    @(posedge clk_i); #1;
    arst_ni = 1'b1;

    $display("[TB] basic ROI from requester 0");
    applyStimulus(0, 100, 50, 200, 150);
    runFrame(16);

    $display("[TB] swapped corners from requester 1");
    applyStimulus(1, 300, 20, 10, 400);
    runFrame(16);

    $display("[TB] rejected requests and boundary corners");
    applyStimulus(0, 800, 10, 5, 5);
    checkActive("rej_hold");
    applyStimulus(1, 5, 600, 6, 7);
    checkActive("rej_hold_y");
    applyStimulus(1, 799, 599, 0, 0);
    runFrame(12);
    applyStimulus(0, 7, 9, 7, 9);
    runFrame(12);

    $display("[TB] ROI replaced mid-frame");
    applyStimulus(0, 11, 22, 33, 44);
    fork
      runFrame(20);
      begin
        repeat (10) @(posedge clk_i);
        applyStimulus(1, 500, 300, 400, 200);
      end
    join
    runFrame(12);

    $display("[TB] reset mid-frame");
    applyStimulus(0, 60, 70, 80, 90);
    repeat (4) begin
      @(posedge clk_i); #1;
    end
    modelStart();
    for (int b = 0; b < 6; b++) begin
      @(posedge clk_i); #1;
      tvalid_i = 1'b1;
    end
    @(posedge clk_i); #1;
    arst_ni  = 1'b0;
    tvalid_i = 1'b0;
    #1;
    checkCleared("rst_mid");
    modelReset();
    @(posedge clk_i); #1;
    arst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    checkCleared("rst_after");

    $display("[TB] both requesters held valid");
    @(posedge clk_i); #1;
    req_xy0_i = {mk(50, 60), mk(1, 2)};
    req_xy1_i = {mk(40, 30), mk(3, 4)};
    req_valid_i = 2'b11;
    runFrame(10);
    runFrame(10);
    runFrame(10);
    @(posedge clk_i); #1;
    req_valid_i = 2'b00;
    for (int k = 0; k < 4 && pend_q.size() > 0; k++) runFrame(10);

    $display("[TB] single request over three frames");
    @(posedge clk_i); #1;
    arst_ni = 1'b0;
    modelReset();
    @(posedge clk_i); #1;
    arst_ni = 1'b1;
    applyStimulus(0, 123, 45, 67, 89);
    done_seen = 0;
    runFrame(8);
    runFrame(8);
    runFrame(8);
    exp_d = 1;
`ifdef ROI_SCHED_REPEAT_EN
    exp_d = 3;
`endif
    checkOutput("done_count", done_seen, exp_d);

    repeat (5) @(negedge clk_i);
    checkOutput("done_q_empty", done_q.size(), 0);
    checkOutput("err_q_empty", err_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
